// File: rtl/j_dncnt_timer_pkg.sv
// Shared constants and types for the Jerry down-count timer.
// Used by the timer, its stage cells and its bus interface.
package j_timer_pkg;

    localparam int J_TIMER_W = 16;

    localparam int J_TIMER_RST = 0;

    typedef logic [J_TIMER_W-1:0] j_cnt_t;

endpackage

// File: rtl/j_dncnt_timer_if.sv
// Register-decode side bundle of the down-count timer.
// J_TIMER_ONESHOT_EN adds the oneshot request and running status.
interface j_dncnt_timer_if #(
    parameter int WIDTH = j_timer_pkg::J_TIMER_W
);

    logic             ce;
    logic             enable;
    logic             pre_wr;
    logic [WIDTH-1:0] pre_din;
    logic             div_wr;
    logic [WIDTH-1:0] div_din;
    logic [WIDTH-1:0] pre_q;
    logic [WIDTH-1:0] div_q;
    logic             tick;
`ifdef J_TIMER_ONESHOT_EN
    logic             oneshot;
    logic             running;
`endif

    modport master (
        output ce,
        output enable,
        output pre_wr,
        output pre_din,
        output div_wr,
        output div_din,
`ifdef J_TIMER_ONESHOT_EN
        output oneshot,
        input  running,
`endif
        input  pre_q,
        input  div_q,
        input  tick
    );

    modport slave (
        input  ce,
        input  enable,
        input  pre_wr,
        input  pre_din,
        input  div_wr,
        input  div_din,
`ifdef J_TIMER_ONESHOT_EN
        input  oneshot,
        output running,
`endif
        output pre_q,
        output div_q,
        output tick
    );

endinterface

// File: rtl/j_dncnt_timer_stage.sv
// One loadable down-count cell: reload register plus count register.
// Borrows and reloads when an advance finds the count at zero.
module j_dncnt_stage #(
    parameter int WIDTH = j_timer_pkg::J_TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             bo
);

    import j_timer_pkg::*;

    logic [WIDTH-1:0] rld;
    logic             zero;

    assign zero = (cnt == '0);

    // A load cancels any borrow in the same cycle.
    assign bo = adv & ~ld & zero;

    // Reload register only changes on an explicit load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rld <= WIDTH'(J_TIMER_RST);
        end else if (ld) begin
            rld <= din;
        end
    end

    // Load wins; otherwise decrement, or reload instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= WIDTH'(J_TIMER_RST);
        end else if (ld) begin
            cnt <= din;
        end else if (adv) begin
            cnt <= zero ? rld : cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/j_dncnt_timer.sv
// Two-stage borrow-chained down-count timer (prescaler -> divider).
// J_TIMER_ONESHOT_EN enables stop-after-one-tick operation.
module j_dncnt_timer #(
    parameter int WIDTH = j_timer_pkg::J_TIMER_W
) (
    input  logic            sys_clk,
    input  logic            reset,
    j_dncnt_timer_if.slave  bus
);

    import j_timer_pkg::*;

    logic adv;
    logic running;
    logic pre_bo;
    logic div_bo;

`ifdef J_TIMER_ONESHOT_EN
    // Armed by a divider write, disarmed by the terminating borrow.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
        end else if (bus.div_wr) begin
            running <= 1'b1;
        end else if (div_bo && bus.oneshot) begin
            running <= 1'b0;
        end
    end

    assign bus.running = running;
`else
    assign running = 1'b1;
`endif

    assign adv = bus.ce & bus.enable & running;

    j_dncnt_stage #(.WIDTH(WIDTH)) u_pre (
        .clk (sys_clk),
        .rst (reset),
        .adv (adv),
        .ld  (bus.pre_wr),
        .din (bus.pre_din),
        .cnt (bus.pre_q),
        .bo  (pre_bo)
    );

    j_dncnt_stage #(.WIDTH(WIDTH)) u_div (
        .clk (sys_clk),
        .rst (reset),
        .adv (pre_bo),
        .ld  (bus.div_wr),
        .din (bus.div_din),
        .cnt (bus.div_q),
        .bo  (div_bo)
    );

    // Register the divider borrow into a one-cycle tick.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bus.tick <= 1'(J_TIMER_RST);
        end else begin
            bus.tick <= div_bo;
        end
    end

endmodule

// File: tb/tb_j_dncnt_timer.sv
// Self-checking bench for j_dncnt_timer: vector table with scoreboard
// plus directed reset and oneshot sequences (J_TIMER_ONESHOT_EN).
module tb_j_dncnt_timer;

    import j_timer_pkg::*;

    typedef struct {
        logic   ce;
        logic   en;
        logic   pw;
        j_cnt_t pd;
        logic   dw;
        j_cnt_t dd;
        j_cnt_t ep;
        j_cnt_t ed;
        logic   et;
    } vec_t;

    typedef struct {
        j_cnt_t ep;
        j_cnt_t ed;
        logic   et;
        int     idx;
    } exp_t;

    logic   sys_clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    vec_t   tbl[$];
    exp_t   sb[$];

    always #5 sys_clk = ~sys_clk;

    j_dncnt_timer_if #(.WIDTH(J_TIMER_W)) bus ();

    j_dncnt_timer #(.WIDTH(J_TIMER_W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ce, input logic en,
                                input logic pw, input int pd,
                                input logic dw, input int dd,
                                input int ep, input int ed,
                                input logic et);
        vec_t v;
        v.ce = ce; v.en = en;
        v.pw = pw; v.pd = j_cnt_t'(pd);
        v.dw = dw; v.dd = j_cnt_t'(dd);
        v.ep = j_cnt_t'(ep); v.ed = j_cnt_t'(ed);
        v.et = et;
        return v;
    endfunction

    task automatic drive(input logic ce, input logic en,
                         input logic pw, input int pd,
                         input logic dw, input int dd);
        bus.ce      = ce;
        bus.enable  = en;
        bus.pre_wr  = pw;
        bus.pre_din = j_cnt_t'(pd);
        bus.div_wr  = dw;
        bus.div_din = j_cnt_t'(dd);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        drive(v.ce, v.en, v.pw, int'(v.pd), v.dw, int'(v.dd));
        sb.push_back('{v.ep, v.ed, v.et, idx});
        @(posedge sys_clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_pre_q", e.idx), 32'(bus.pre_q), 32'(e.ep));
            chk($sformatf("v%0d_div_q", e.idx), 32'(bus.div_q), 32'(e.ed));
            chk($sformatf("v%0d_tick", e.idx), 32'(bus.tick), 32'(e.et));
        end
    endtask

    task automatic step_chk(input string name, input int ep,
                            input int ed, input logic et);
        @(posedge sys_clk);
        #1;
        chk({name, "_pre_q"}, 32'(bus.pre_q), 32'(ep));
        chk({name, "_div_q"}, 32'(bus.div_q), 32'(ed));
        chk({name, "_tick"}, 32'(bus.tick), 32'(et));
    endtask

    task automatic build_table();
        int a;
        logic advd;
        // zero reloads: tick every advance edge, none on hold
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
        // pre=2 div=3, ce constant: period 12
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 2, 3, 0));
        for (int k = 1; k <= 26; k++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2 - (k % 3),
                             3 - ((k / 3) % 4), (k % 12) == 0));
        // ce every other cycle: period 24
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 2, 3, 0));
        for (int j = 1; j <= 50; j++) begin
            a = (j + 1) / 2;
            advd = (j % 2) == 1;
            tbl.push_back(mk(advd, 1, 0, 0, 0, 0, 2 - (a % 3),
                             3 - ((a / 3) % 4),
                             advd && (a % 12) == 0));
        end
        // enable low for 5 cycles: first tick shifts to 17
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 2, 3, 0));
        a = 0;
        for (int k = 1; k <= 22; k++) begin
            advd = !(k >= 4 && k <= 8);
            if (advd) a++;
            tbl.push_back(mk(1, advd, 0, 0, 0, 0, 2 - (a % 3),
                             3 - ((a / 3) % 4),
                             advd && a > 0 && (a % 12) == 0));
        end
        // divider write on its own underflow edge
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 2, 3, 0));
        for (int k = 1; k <= 11; k++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2 - (k % 3),
                             3 - ((k / 3) % 4), 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 7, 2, 7, 0));
        for (int m = 1; m <= 26; m++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2 - (m % 3),
                             7 - ((m / 3) % 8), m == 24));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef J_TIMER_ONESHOT_EN
        bus.oneshot = 1'b0;
`endif
        #3;
        chk("rst_pre_q", 32'(bus.pre_q), 32'd0);
        chk("rst_div_q", 32'(bus.div_q), 32'd0);
        chk("rst_tick", 32'(bus.tick), 32'd0);
`ifdef J_TIMER_ONESHOT_EN
        chk("rst_running", 32'(bus.running), 32'd0);
`endif
        @(posedge sys_clk);
        #1;
        reset = 1'b0;

        // async reset clears a pending tick
        drive(1, 1, 1, 0, 1, 0);
        step_chk("z_load", 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        step_chk("z_run", 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tick", 32'(bus.tick), 32'd0);
        #1;
        reset = 1'b0;

        // async reset mid-count at pre_cnt=5
        drive(1, 1, 1, 9, 1, 2);
        step_chk("m_load", 9, 2, 0);
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            step_chk($sformatf("m_dec%0d", k), 9 - k, 2, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_pre_q", 32'(bus.pre_q), 32'd0);
        chk("mrst_div_q", 32'(bus.div_q), 32'd0);
        chk("mrst_tick", 32'(bus.tick), 32'd0);
        step_chk("mrst_hold", 0, 0, 0);
        reset = 1'b0;
        drive(1, 1, 0, 0, 1, 0);
        step_chk("restart_wr", 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        step_chk("restart_run", 0, 0, 1);

        build_table();
        foreach (tbl[i]) run_vec(tbl[i], i);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

`ifdef J_TIMER_ONESHOT_EN
        bus.oneshot = 1'b1;
        drive(1, 1, 1, 1, 1, 1);
        step_chk("os_load", 1, 1, 0);
        chk("os_run0", 32'(bus.running), 32'd1);
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge sys_clk);
            #1;
            chk($sformatf("os_tick%0d", k), 32'(bus.tick), 32'(k == 4));
            chk($sformatf("os_run%0d", k), 32'(bus.running), 32'(k < 4));
        end
        chk("os_pre_hold", 32'(bus.pre_q), 32'd1);
        chk("os_div_hold", 32'(bus.div_q), 32'd1);
        drive(1, 1, 0, 0, 1, 1);
        step_chk("os_rearm", 1, 1, 0);
        chk("os_run_rearm", 32'(bus.running), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
